// File: rtl/time_set_ctrl_if.sv
// Board-side I/O bundle for the clock set-mode sequencer:
// raw pushbutton/switch inputs and datapath control pulses.
interface time_set_ctrl_if;
  logic incr_pb;
  logic decr_pb;
  logic min_set_switch;
  logic tick_1hz;
  logic sec_clr;
  logic adj_incr;
  logic adj_decr;
  logic set_mode;

  modport master (
    output incr_pb, decr_pb, min_set_switch,
    input  tick_1hz, sec_clr, adj_incr, adj_decr, set_mode
  );

  modport slave (
    input  incr_pb, decr_pb, min_set_switch,
    output tick_1hz, sec_clr, adj_incr, adj_decr, set_mode
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-set sequencer: input debounce, 1 Hz prescaler, set-mode FSM.
// Define REPEAT_ACCEL_EN to speed up auto-repeat after 8 pulses.
module time_set_ctrl #(
  parameter int CLK_HZ              = 5000000,
  parameter int DEBOUNCE_CYCLES     = 50000,
  parameter int REPEAT_DELAY_CYCLES = 2500000,
  parameter int REPEAT_RATE_CYCLES  = 500000
) (
  input logic           clk_5M,
  input logic           reset,
  time_set_ctrl_if.slave io
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX =
    (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
    REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;

  typedef enum logic [2:0] {
    RUN, SET_IDLE, SET_HOLD, SET_REPEAT, SET_BOTH
  } state_t;

  // bit 0 = incr, bit 1 = decr, bit 2 = mode switch
  logic [2:0]    w_raw;
  logic [2:0]    r_s1;
  logic [2:0]    r_s2;
  logic [2:0]    r_db;
  logic [1:0]    r_db_q;
  logic [1:0]    r_ev;
  logic [DW-1:0] r_dcnt [3];

  state_t        r_state;
  logic [PW-1:0] r_pre;
  logic [RW-1:0] r_rcnt;
  logic          r_held;
  logic          r_tick;
  logic          r_clr;
  logic          r_inc;
  logic          r_dec;
  logic          r_set;

  logic w_sw;
  logic w_hold_btn;
  logic w_other_btn;
  logic w_dly_hit;
  logic w_rep_hit;
  logic w_hit;

  assign w_raw = {io.min_set_switch, io.decr_pb, io.incr_pb};

  always_ff @(posedge clk_5M) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_db   <= '0;
      r_db_q <= '0;
      r_ev   <= '0;
      for (int i = 0; i < 3; i++) r_dcnt[i] <= '0;
    end else begin
      r_s1   <= w_raw;
      r_s2   <= r_s1;
      r_db_q <= r_db[1:0];
      r_ev   <= r_db[1:0] & ~r_db_q;
      for (int i = 0; i < 3; i++) begin
        if (r_s2[i] == r_db[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_db[i]   <= r_s2[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_sw        = r_db[2];
  assign w_hold_btn  = r_held ? r_db[1] : r_db[0];
  assign w_other_btn = r_held ? r_db[0] : r_db[1];
  assign w_dly_hit   = r_rcnt == RW'(REPEAT_DELAY_CYCLES - 1);
  assign w_hit = (r_state == SET_HOLD) ? w_dly_hit : w_rep_hit;

`ifdef REPEAT_ACCEL_EN
  localparam int FAST =
    (REPEAT_RATE_CYCLES / 4 > 0) ? REPEAT_RATE_CYCLES / 4 : 1;
  logic [3:0] r_npulse;
  logic       w_rep_pulse;

  assign w_rep_hit = r_npulse[3] ?
    (r_rcnt == RW'(FAST - 1)) :
    (r_rcnt == RW'(REPEAT_RATE_CYCLES - 1));
  assign w_rep_pulse = (r_state == SET_REPEAT) && w_sw &&
    !w_other_btn && w_hold_btn && w_rep_hit;

  // counts pulses within one SET_REPEAT stay, saturating at 8
  always_ff @(posedge clk_5M) begin
    if (reset || r_state != SET_REPEAT) begin
      r_npulse <= '0;
    end else if (w_rep_pulse && !r_npulse[3]) begin
      r_npulse <= r_npulse + 1'b1;
    end
  end
`else
  assign w_rep_hit = r_rcnt == RW'(REPEAT_RATE_CYCLES - 1);
`endif

  always_ff @(posedge clk_5M) begin
    if (reset) begin
      r_state <= RUN;
      r_pre   <= '0;
      r_rcnt  <= '0;
      r_held  <= 1'b0;
      r_tick  <= 1'b0;
      r_clr   <= 1'b0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_set   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_clr  <= 1'b0;
      r_inc  <= 1'b0;
      r_dec  <= 1'b0;
      if (r_state != RUN && !w_sw) begin
        r_state <= RUN;
        r_set   <= 1'b0;
        r_rcnt  <= '0;
      end else begin
        unique case (r_state)
          RUN: begin
            if (w_sw) begin
              r_state <= SET_IDLE;
              r_clr   <= 1'b1;
              r_set   <= 1'b1;
              r_pre   <= '0;
            end else if (r_pre == PW'(CLK_HZ - 1)) begin
              r_pre  <= '0;
              r_tick <= 1'b1;
            end else begin
              r_pre <= r_pre + 1'b1;
            end
          end
          SET_IDLE: begin
            if (r_db[1:0] == 2'b11) begin
              r_state <= SET_BOTH;
            end else if (r_ev == 2'b01 || r_ev == 2'b10) begin
              r_held  <= r_ev[1];
              r_inc   <= r_ev[0];
              r_dec   <= r_ev[1];
              r_rcnt  <= '0;
              r_state <= SET_HOLD;
            end
          end
          SET_HOLD, SET_REPEAT: begin
            if (w_other_btn) begin
              r_state <= SET_BOTH;
              r_rcnt  <= '0;
            end else if (!w_hold_btn) begin
              r_state <= SET_IDLE;
              r_rcnt  <= '0;
            end else if (w_hit) begin
              r_inc   <= ~r_held;
              r_dec   <= r_held;
              r_rcnt  <= '0;
              r_state <= SET_REPEAT;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
          SET_BOTH: begin
            if (r_db[1:0] == 2'b00) r_state <= SET_IDLE;
          end
          default: r_state <= RUN;
        endcase
      end
    end
  end

  assign io.tick_1hz = r_tick;
  assign io.sec_clr  = r_clr;
  assign io.adj_incr = r_inc;
  assign io.adj_decr = r_dec;
  assign io.set_mode = r_set;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: random press/hold/switch timing checked
// against pulse schedules derived arithmetically from the rules.
module tb_time_set_ctrl;
  localparam int HZ   = 20;
  localparam int DB   = 4;
  localparam int DLY  = 16;
  localparam int RATE = 5;
`ifdef REPEAT_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic clk_5M = 1'b0;
  logic reset  = 1'b1;

  time_set_ctrl_if io ();

  time_set_ctrl #(
    .CLK_HZ(HZ),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY_CYCLES(DLY),
    .REPEAT_RATE_CYCLES(RATE)
  ) dut (
    .clk_5M(clk_5M),
    .reset(reset),
    .io(io.slave)
  );

  always #5 clk_5M = ~clk_5M;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int n_both = 0;
  int q_inc[$];
  int q_dec[$];
  int q_clr[$];
  int q_tick[$];
  int exp_q[$];

  always @(posedge clk_5M) cyc <= cyc + 1;

  // pulse log, stamped with the clock edge that produced the pulse
  always @(negedge clk_5M) begin
    if (io.tick_1hz === 1'b1) q_tick.push_back(cyc);
    if (io.sec_clr === 1'b1) q_clr.push_back(cyc);
    if (io.adj_incr === 1'b1) q_inc.push_back(cyc);
    if (io.adj_decr === 1'b1) q_dec.push_back(cyc);
    if (io.adj_incr === 1'b1 && io.adj_decr === 1'b1)
      n_both++;
  end

  // Raw edge after edge t: debounced change at t+DB+2, press pulse
  // at t+DB+4. Pulses then follow at +DLY, then +RATE (or RATE/4
  // after 8 repeats) while the FSM still sees the button at edge last.
  task automatic exp_hold(input int p, input int last);
    int t;
    int n;
    exp_q.delete();
    if (p > last) return;
    exp_q.push_back(p);
    t = p + DLY;
    n = 0;
    while (t <= last) begin
      exp_q.push_back(t);
      n++;
      t += (ACCEL && n > 8) ? RATE / 4 : RATE;
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    if (b == 1) io.decr_pb = v;
    else io.incr_pb = v;
  endtask

  task automatic clear_logs();
    q_inc.delete();
    q_dec.delete();
    q_clr.delete();
    q_tick.delete();
  endtask

  task automatic test_reset();
    logic [4:0] o;
    io.incr_pb = 1'b0;
    io.decr_pb = 1'b0;
    io.min_set_switch = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk_5M);
    o = {io.tick_1hz, io.sec_clr, io.adj_incr,
         io.adj_decr, io.set_mode};
    total++;
    if (o !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b need 00000", o);
    end
  endtask

  task automatic test_tick();
    int r0;
    bit ok;
    clear_logs();
    @(negedge clk_5M);
    reset = 1'b0;
    r0 = cyc;
    repeat (62) @(negedge clk_5M);
    exp_q.delete();
    for (int k = 1; k <= 3; k++) exp_q.push_back(r0 + k * HZ);
    total++;
    ok = q_tick.size() == exp_q.size();
    foreach (exp_q[i]) if (ok && q_tick[i] !== exp_q[i]) ok = 0;
    if (!ok) begin
      bad++;
      $display("FAIL tick_run: got %p need %p", q_tick, exp_q);
    end
    total++;
    if (q_clr.size() + q_inc.size() + q_dec.size() !== 0) begin
      bad++;
      $display("FAIL run_quiet: got %0d pulses need 0",
               q_clr.size() + q_inc.size() + q_dec.size());
    end
    total++;
    if (io.set_mode !== 1'b0) begin
      bad++;
      $display("FAIL run_set_mode: got %b need 0", io.set_mode);
    end
  endtask

  task automatic test_enter_set();
    int t0;
    int late;
    clear_logs();
    repeat ($urandom_range(0, 7)) @(negedge clk_5M);
    @(negedge clk_5M);
    io.min_set_switch = 1'b1;
    t0 = cyc;
    repeat (30) @(negedge clk_5M);
    total++;
    if (q_clr.size() !== 1 || q_clr[0] !== t0 + 7) begin
      bad++;
      $display("FAIL sec_clr: got %p need [%0d]", q_clr, t0 + 7);
    end
    total++;
    if (io.set_mode !== 1'b1) begin
      bad++;
      $display("FAIL set_mode_on: got %b need 1", io.set_mode);
    end
    late = 0;
    foreach (q_tick[i]) if (q_tick[i] >= t0 + 7) late++;
    total++;
    if (late !== 0) begin
      bad++;
      $display("FAIL tick_in_set: got %0d ticks need 0", late);
    end
  endtask

  task automatic test_glitch();
    int g;
    int h;
    int t0;
    bit ok;
    clear_logs();
    g = $urandom_range(1, 3);
    @(negedge clk_5M);
    io.incr_pb = 1'b1;
    repeat (g) @(negedge clk_5M);
    io.incr_pb = 1'b0;
    repeat (12) @(negedge clk_5M);
    total++;
    if (q_inc.size() + q_dec.size() !== 0) begin
      bad++;
      $display("FAIL glitch_%0d: got %0d pulses need 0",
               g, q_inc.size() + q_dec.size());
    end
    h = $urandom_range(6, 12);
    @(negedge clk_5M);
    io.incr_pb = 1'b1;
    t0 = cyc;
    repeat (h) @(negedge clk_5M);
    io.incr_pb = 1'b0;
    repeat (20) @(negedge clk_5M);
    exp_hold(t0 + DB + 4, t0 + h + DB + 2);
    total++;
    ok = q_inc.size() == exp_q.size();
    foreach (exp_q[i]) if (ok && q_inc[i] !== exp_q[i]) ok = 0;
    if (!ok) begin
      bad++;
      $display("FAIL short_press: got %p need %p", q_inc, exp_q);
    end
    total++;
    if (q_dec.size() !== 0) begin
      bad++;
      $display("FAIL short_press_dec: got %0d need 0", q_dec.size());
    end
  endtask

  task automatic test_hold();
    int h;
    int t0;
    int got[$];
    int other;
    bit ok;
    for (int b = 0; b < 2; b++) begin
      for (int it = 0; it < 2; it++) begin
        clear_logs();
        h = $urandom_range(30, 70);
        @(negedge clk_5M);
        set_btn(b, 1'b1);
        t0 = cyc;
        repeat (h) @(negedge clk_5M);
        set_btn(b, 1'b0);
        repeat (15) @(negedge clk_5M);
        exp_hold(t0 + DB + 4, t0 + h + DB + 2);
        got = (b == 1) ? q_dec : q_inc;
        other = (b == 1) ? q_inc.size() : q_dec.size();
        total++;
        ok = got.size() == exp_q.size();
        foreach (exp_q[i]) if (ok && got[i] !== exp_q[i]) ok = 0;
        if (!ok) begin
          bad++;
          $display("FAIL hold_b%0d_h%0d: got %p need %p",
                   b, h, got, exp_q);
        end
        total++;
        if (other !== 0) begin
          bad++;
          $display("FAIL hold_b%0d_other: got %0d need 0", b, other);
        end
      end
    end
  endtask

  task automatic test_both();
    int t0;
    int t1;
    int t2;
    int k;
    bit ok;
    clear_logs();
    k = $urandom_range(20, 35);
    @(negedge clk_5M);
    io.decr_pb = 1'b1;
    t0 = cyc;
    repeat (k) @(negedge clk_5M);
    io.incr_pb = 1'b1;
    t1 = cyc;
    repeat (12) @(negedge clk_5M);
    io.decr_pb = 1'b0;
    repeat (8) @(negedge clk_5M);
    io.incr_pb = 1'b0;
    repeat (12) @(negedge clk_5M);
    exp_hold(t0 + DB + 4, t1 + DB + 2);
    total++;
    ok = q_dec.size() == exp_q.size();
    foreach (exp_q[i]) if (ok && q_dec[i] !== exp_q[i]) ok = 0;
    if (!ok) begin
      bad++;
      $display("FAIL both_decr: got %p need %p", q_dec, exp_q);
    end
    total++;
    if (q_inc.size() !== 0) begin
      bad++;
      $display("FAIL both_incr: got %0d pulses need 0", q_inc.size());
    end
    clear_logs();
    @(negedge clk_5M);
    io.incr_pb = 1'b1;
    t2 = cyc;
    repeat (8) @(negedge clk_5M);
    io.incr_pb = 1'b0;
    repeat (15) @(negedge clk_5M);
    total++;
    if (q_inc.size() !== 1 || q_inc[0] !== t2 + DB + 4) begin
      bad++;
      $display("FAIL after_both: got %p need [%0d]",
               q_inc, t2 + DB + 4);
    end
    total++;
    if (q_dec.size() !== 0) begin
      bad++;
      $display("FAIL after_both_dec: got %0d need 0", q_dec.size());
    end
  endtask

  task automatic test_exit();
    int t0;
    int ts;
    int first;
    bit ok;
    clear_logs();
    @(negedge clk_5M);
    io.incr_pb = 1'b1;
    t0 = cyc;
    repeat ($urandom_range(30, 45)) @(negedge clk_5M);
    io.min_set_switch = 1'b0;
    ts = cyc;
    repeat (10) @(negedge clk_5M);
    io.incr_pb = 1'b0;
    repeat (30) @(negedge clk_5M);
    exp_hold(t0 + DB + 4, ts + DB + 2);
    total++;
    ok = q_inc.size() == exp_q.size();
    foreach (exp_q[i]) if (ok && q_inc[i] !== exp_q[i]) ok = 0;
    if (!ok) begin
      bad++;
      $display("FAIL exit_pulses: got %p need %p", q_inc, exp_q);
    end
    first = (q_tick.size() > 0) ? q_tick[0] : -1;
    total++;
    if (first !== ts + DB + 3 + HZ) begin
      bad++;
      $display("FAIL exit_tick: got %0d need %0d",
               first, ts + DB + 3 + HZ);
    end
    total++;
    if (io.set_mode !== 1'b0) begin
      bad++;
      $display("FAIL exit_set_mode: got %b need 0", io.set_mode);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] o;
    @(negedge clk_5M);
    io.min_set_switch = 1'b1;
    repeat (12) @(negedge clk_5M);
    io.incr_pb = 1'b1;
    repeat ($urandom_range(32, 40)) @(negedge clk_5M);
    total++;
    if (io.set_mode !== 1'b1) begin
      bad++;
      $display("FAIL mid_set_mode: got %b need 1", io.set_mode);
    end
    reset = 1'b1;
    @(negedge clk_5M);
    o = {io.tick_1hz, io.sec_clr, io.adj_incr,
         io.adj_decr, io.set_mode};
    total++;
    if (o !== 5'b0) begin
      bad++;
      $display("FAIL mid_reset: got %b need 00000", o);
    end
    io.incr_pb = 1'b0;
    io.min_set_switch = 1'b0;
    repeat (3) @(negedge clk_5M);
    reset = 1'b0;
    repeat (3) @(negedge clk_5M);
  endtask

  task automatic test_exclusive();
    total++;
    if (n_both !== 0) begin
      bad++;
      $display("FAIL adj_exclusive: got %0d overlaps need 0", n_both);
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_enter_set();
    test_glitch();
    test_hold();
    test_both();
    test_exit();
    test_reset_mid();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
